// File: rtl/ex_mem_pkg.sv
// Shared core defines plus the EX/MEM stage field bundle and per-edge action decode.
package ex_mem_pkg;

  localparam int unsigned RegAddrBus   = 5;
  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned StallBus     = 6;
  localparam int unsigned CntBus       = 2;

  localparam logic RstEnable    = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;

  // Bit positions inside the control unit's stall vector.
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;

  typedef enum logic [1:0] {
    ActHold,
    ActAdvance,
    ActBubble,
    ActFlush
  } stage_act_e;

  typedef struct packed {
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  whilo;
  } pipe_fields_t;

  localparam pipe_fields_t BubbleFields = '{
    wd:    NOPRegAddr,
    wreg:  WriteDisable,
    wdata: ZeroWord,
    hi:    ZeroWord,
    lo:    ZeroWord,
    whilo: WriteDisable
  };

  // Flush beats any stall; execute-stalled-with-memory-running is a bubble;
  // execute running always advances, even with the illegal memory-only stall.
  function automatic stage_act_e decode_act(logic flush, logic stall_ex, logic stall_mem);
    if (flush == Stop)         return ActFlush;
    if (stall_ex == NoStop)    return ActAdvance;
    if (stall_mem == NoStop)   return ActBubble;
    return ActHold;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// Register-write / HI-LO result bundle passed between adjacent pipeline stages.
interface ex_mem_if;
  import ex_mem_pkg::*;

  logic [RegAddrBus-1:0] wd;
  logic                  wreg;
  logic [RegBus-1:0]     wdata;
  logic [RegBus-1:0]     hi;
  logic [RegBus-1:0]     lo;
  logic                  whilo;

  modport master (output wd, wreg, wdata, hi, lo, whilo);
  modport slave  (input  wd, wreg, wdata, hi, lo, whilo);
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall, bubble and flush, plus the madd/msub feedback
// accumulator, which is built only when MADD_MSUB_EN is defined.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic                    flush,
  ex_mem_if.slave                 ex,
  ex_mem_if.master                mem,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [CntBus-1:0]       cnt_i,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [CntBus-1:0]       cnt_o
);

  stage_act_e   act;
  pipe_fields_t ex_fields;
  pipe_fields_t fields_d, fields_q;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  assign act = decode_act(flush, stall[StallEx], stall[StallMem]);

  assign ex_fields = '{
    wd:    ex.wd,
    wreg:  ex.wreg,
    wdata: ex.wdata,
    hi:    ex.hi,
    lo:    ex.lo,
    whilo: ex.whilo
  };

  always_comb begin
    fields_d = fields_q;
    case (act)
      ActFlush,
      ActBubble:  fields_d = BubbleFields;
      ActAdvance: fields_d = ex_fields;
      default:    fields_d = fields_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      fields_q <= BubbleFields;
    end else begin
      fields_q <= fields_d;
    end
  end

  assign mem.wd    = fields_q.wd;
  assign mem.wreg  = fields_q.wreg;
  assign mem.wdata = fields_q.wdata;
  assign mem.hi    = fields_q.hi;
  assign mem.lo    = fields_q.lo;
  assign mem.whilo = fields_q.whilo;

`ifdef MADD_MSUB_EN
  logic [DoubleRegBus-1:0] hilo_d, hilo_q;
  logic [CntBus-1:0]       cnt_d, cnt_q;

  // The partial product is only kept across a bubble; any advance or flush ends the op.
  always_comb begin
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    case (act)
      ActBubble: begin
        hilo_d = hilo_i;
        cnt_d  = cnt_i;
      end
      ActFlush,
      ActAdvance: begin
        hilo_d = '0;
        cnt_d  = '0;
      end
      default: begin
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hilo_o = hilo_q;
  assign cnt_o  = cnt_q;
`else
  logic unused_fb;
  assign unused_fb = ^{hilo_i, cnt_i};

  assign hilo_o = '0;
  assign cnt_o  = '0;
`endif

endmodule
